univ_shift_reg: RTL



---
 rtl/univ_shift_pkg.sv | 31 +++
 rtl/univ_shift_step.sv | 67 ++++++
 rtl/univ_shift_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
// ============================================================================
// Module   : univ_shift_pkg
// Brief    : Shared operation and state encodings for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        HOLD  = 3'd0,
        SHL   = 3'd1,
        SHR   = 3'd2,
        ROL   = 3'd3,
        ROR   = 3'd4,
        ASR   = 3'd5,
        LOAD  = 3'd6,
        CLEAR = 3'd7
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } shift_st_e;

endpackage

`default_nettype wire

// File: rtl/univ_shift_step.sv
// ============================================================================
// Module   : univ_shift_step
// Brief    : Combinational single-step next-q / outgoing-lane function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANE  = 1
) (
    input  logic [WIDTH-1:0] i_q,
    input  shift_op_e        i_op,
    input  logic [LANE-1:0]  i_sin,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [WIDTH-1:0] o_q_next,
    output logic [LANE-1:0]  o_sout_next,
    output logic             o_sout_upd
);

    logic [LANE-1:0] w_top;
    logic [LANE-1:0] w_bot;

    assign w_top = i_q[WIDTH-1:WIDTH-LANE];
    assign w_bot = i_q[LANE-1:0];

    always_comb begin
        o_q_next    = i_q;
        o_sout_next = '0;
        o_sout_upd  = 1'b0;
        case (i_op)
            SHL: begin
                o_q_next    = {i_q[WIDTH-LANE-1:0], i_sin};
                o_sout_next = w_top;
                o_sout_upd  = 1'b1;
            end
            SHR: begin
                o_q_next    = {i_sin, i_q[WIDTH-1:LANE]};
                o_sout_next = w_bot;
                o_sout_upd  = 1'b1;
            end
            ROL: begin
                o_q_next    = {i_q[WIDTH-LANE-1:0], w_top};
                o_sout_next = w_top;
                o_sout_upd  = 1'b1;
            end
            ROR: begin
                o_q_next    = {w_bot, i_q[WIDTH-1:LANE]};
                o_sout_next = w_bot;
                o_sout_upd  = 1'b1;
            end
            ASR: begin
                o_q_next    = {{LANE{i_q[WIDTH-1]}}, i_q[WIDTH-1:LANE]};
                o_sout_next = w_bot;
                o_sout_upd  = 1'b1;
            end
            LOAD:    o_q_next = i_pdata;
            CLEAR:   o_q_next = '0;
            default: o_q_next = i_q;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal lane shift register with counted burst engine.
//            Optional parity output enabled by defining UNIV_SHIFT_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANE  = 1,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic [LANE-1:0]  sin,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNTW-1:0]  cnt,
    output logic [WIDTH-1:0] q,
    output logic [LANE-1:0]  sout,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHIFT_PARITY_EN
    ,
    output logic             parity
`endif
);

    shift_st_e        r_state;
    shift_op_e        r_op;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [LANE-1:0]  r_sout;
    logic             r_busy;
    logic             r_done;

    shift_op_e        w_step_op;
    logic             w_apply;
    logic [WIDTH-1:0] w_q_next;
    logic [LANE-1:0]  w_sout_next;
    logic             w_sout_upd;

    // A burst uses the latched op; a zero-length start performs no step.
    assign w_step_op = (r_state == RUN) ? r_op : shift_op_e'(op);
    assign w_apply   = (r_state == RUN) ||
                       ((r_state == IDLE) && !(start && (cnt == '0)));

    univ_shift_step #(
        .WIDTH (WIDTH),
        .LANE  (LANE)
    ) u_step (
        .i_q         (r_q),
        .i_op        (w_step_op),
        .i_sin       (sin),
        .i_pdata     (pdata),
        .o_q_next    (w_q_next),
        .o_sout_next (w_sout_next),
        .o_sout_upd  (w_sout_upd)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_op    <= HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (en) begin
            if (w_apply) begin
                r_q <= w_q_next;
                if (w_sout_upd) begin
                    r_sout <= w_sout_next;
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= shift_op_e'(op);
                        if (cnt == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= cnt - CNTW'(1);
                            if (cnt == CNTW'(1)) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

`ifdef UNIV_SHIFT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_parity <= 1'b0;
        end else if (en && w_apply) begin
            r_parity <= ^w_q_next;
        end
    end

    assign parity = r_parity;
`endif

endmodule

`default_nettype wire
